project_period_counter_slave: RTL

- Slave period counter; the receiving end of the master counter's sync pulse.
- Runs the same OFF/UP/DOWN/UP_DOWN counting modes against a shadowed period.
- On an accepted sync pulse it loads a programmable phase value (and, in UP_DOWN, a direction), giving phase-shifted PWM channels.
- Regenerates its own sync output so slaves can be daisy-chained.

---
 rtl/project_period_counter_slave.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/project_period_counter_slave.sv
// Slave period counter: follows the master's sync pulse by loading a phase value,
// counts UP/DOWN/UP_DOWN against a shadowed period and regenerates a sync output.
module project_period_counter_slave #(
    parameter int WIDTH = 16
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_en,
    input  logic [1:0]         i_mode,
    input  logic [WIDTH-1:0]   i_period,
    input  logic               i_sync,
    input  logic               i_sync_in_en,
    input  logic [WIDTH-1:0]   i_phase,
    input  logic               i_phase_dir,
    input  logic               i_sync_out_en,
    input  logic               i_sync_passthru,
    input  logic [1:0]         i_sync_sel,
    input  logic [WIDTH-1:0]   i_compare_b,
    input  logic               i_clear_status,
    output logic [WIDTH-1:0]   o_period,
    output logic [WIDTH-1:0]   o_period_next,
    output logic               o_dir,
    output logic               o_sync,
    output logic               o_synced
);

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_UD   = 2'b11;

    localparam logic [1:0] SEL_ZERO   = 2'b00;
    localparam logic [1:0] SEL_PERIOD = 2'b01;
    localparam logic [1:0] SEL_CB_UP  = 2'b10;
    localparam logic [1:0] SEL_CB_DN  = 2'b11;

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] per_q, per_d;
    logic             dir_q, dir_d;
    logic             sync_q, sync_d;
    logic             synced_q, synced_d;

    logic             accept_s;
    logic             wrap_s;
    logic             match_s;
    logic [WIDTH-1:0] phase_clamp_s;

    // Sync acceptance, clamped phase and end-of-cycle detection for the period shadow
    always_comb begin
        accept_s      = i_sync & i_sync_in_en & i_en & (i_mode != MODE_OFF);
        phase_clamp_s = (i_phase < i_period) ? i_phase : i_period;
        case (i_mode)
            MODE_UP:   wrap_s = (cnt_q == per_q);
            MODE_DOWN: wrap_s = (cnt_q == ZERO_W);
            MODE_UD:   wrap_s = (cnt_q == ZERO_W) & dir_q;
            default:   wrap_s = 1'b0;
        endcase
    end

    // Next counter, direction and active period
    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        per_d = per_q;
        if (!i_en) begin
            cnt_d = cnt_q;
            dir_d = dir_q;
            per_d = per_q;
        end else if (accept_s) begin
            cnt_d = phase_clamp_s;
            per_d = i_period;
            if (i_mode == MODE_UD) begin
                dir_d = i_phase_dir;
            end else begin
                dir_d = dir_q;
            end
        end else begin
            if ((i_mode == MODE_OFF) || wrap_s) begin
                per_d = i_period;
            end else begin
                per_d = per_q;
            end
            if (per_q == ZERO_W) begin
                cnt_d = ZERO_W;
                dir_d = 1'b0;
            end else begin
                case (i_mode)
                    MODE_UP: begin
                        cnt_d = (cnt_q == per_q) ? ZERO_W : cnt_q + ONE_W;
                    end
                    MODE_DOWN: begin
                        cnt_d = (cnt_q == ZERO_W) ? per_q : cnt_q - ONE_W;
                    end
                    MODE_UD: begin
                        // Turning points: >= also catches a phase loaded equal to the period
                        if (!dir_q) begin
                            if (cnt_q >= per_q) begin
                                cnt_d = per_q - ONE_W;
                                dir_d = 1'b1;
                            end else begin
                                cnt_d = cnt_q + ONE_W;
                            end
                        end else begin
                            if (cnt_q == ZERO_W) begin
                                cnt_d = ONE_W;
                                dir_d = 1'b0;
                            end else begin
                                cnt_d = cnt_q - ONE_W;
                            end
                        end
                    end
                    default: begin
                        cnt_d = cnt_q;
                    end
                endcase
            end
        end
    end

    // Local sync event match on the upcoming counter state, plus status flag
    always_comb begin
        case (i_sync_sel)
            SEL_ZERO:   match_s = (cnt_d == ZERO_W);
            SEL_PERIOD: match_s = (cnt_d == per_d);
            SEL_CB_UP:  match_s = (cnt_d == i_compare_b) & ~dir_d;
            SEL_CB_DN:  match_s = (cnt_d == i_compare_b) & dir_d;
            default:    match_s = 1'b0;
        endcase
        if (i_sync_passthru) begin
            sync_d = i_sync;
        end else begin
            sync_d = i_en & match_s;
        end
        if (accept_s) begin
            synced_d = 1'b1;
        end else if (i_clear_status) begin
            synced_d = 1'b0;
        end else begin
            synced_d = synced_q;
        end
    end

    // State registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q    <= ZERO_W;
            per_q    <= ZERO_W;
            dir_q    <= 1'b0;
            sync_q   <= 1'b0;
            synced_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            per_q    <= per_d;
            dir_q    <= dir_d;
            sync_q   <= sync_d;
            synced_q <= synced_d;
        end
    end

    assign o_period      = cnt_q;
    assign o_period_next = cnt_d;
    assign o_dir         = dir_q;
    assign o_sync        = sync_q & i_sync_out_en;
    assign o_synced      = synced_q;

endmodule
